// File: rtl/snoop_pkg.sv
// Shared types and instruction-field layout helpers for the snoop-bus request port.
// Instruction layout, MSB first: {id, write, read, tag, data}.
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic write;
    logic read;
  } op_cmd_t;

  function automatic int tag_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rd_bit(input int tag_w, input int data_w);
    return tag_w + data_w;
  endfunction

  function automatic int wr_bit(input int tag_w, input int data_w);
    return tag_w + data_w + 1;
  endfunction

  function automatic int id_lsb(input int tag_w, input int data_w);
    return tag_w + data_w + 2;
  endfunction

  function automatic int instr_w(input int id_w, input int tag_w, input int data_w);
    return id_w + 2 + tag_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_req_port_if.sv
// Instruction, snoop-bus and read-result signals of one CPU request port.
// master: the port itself; slave: the instruction source / bus side.
interface cpu_req_port_if #(
  parameter int ID_W   = 2,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 16
);
  import snoop_pkg::*;

  localparam int INSTR_W = instr_w(ID_W, TAG_W, DATA_W);

  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               instr_ready;
  logic               bus_req;
  logic               bus_gnt;
  logic               writeOut;
  logic               readOut;
  logic [TAG_W-1:0]   tagOut;
  logic [DATA_W-1:0]  dataOut;
  logic               result_valid;
  logic [TAG_W-1:0]   result_tag;
  logic [DATA_W-1:0]  result_data;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;
  logic               err;

  modport master (
    input  instruction, instr_valid, bus_gnt, result_valid, result_tag, result_data,
    output instr_ready, bus_req, writeOut, readOut, tagOut, dataOut, rd_valid, rd_data, err
  );

  modport slave (
    output instruction, instr_valid, bus_gnt, result_valid, result_tag, result_data,
    input  instr_ready, bus_req, writeOut, readOut, tagOut, dataOut, rd_valid, rd_data, err
  );

endinterface

// File: rtl/snoop_fifo.sv
// Small synchronous FIFO (power-of-two DEPTH) holding decoded operations.
// Push and pop in the same cycle both take effect; no bypass from push to pop.
module snoop_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_req_port.sv
// Per-CPU snoop-bus request port: claims instructions for CPU_ID, queues them, and
// issues one bus transaction each. Optional read timeout: CPU_REQ_PORT_TIMEOUT_EN.
module cpu_req_port
  import snoop_pkg::*;
#(
  parameter int CPU_ID  = 1,
  parameter int ID_W    = 2,
  parameter int TAG_W   = 12,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic          clock,
  input logic          reset_n,
  cpu_req_port_if.master bus
);

  localparam int TagLsb = tag_lsb(DATA_W);
  localparam int RdBit  = rd_bit(TAG_W, DATA_W);
  localparam int WrBit  = wr_bit(TAG_W, DATA_W);
  localparam int IdLsb  = id_lsb(TAG_W, DATA_W);

  typedef struct packed {
    op_cmd_t           cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } op_t;

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  op_t               push_op, fifo_head;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              fifo_full, fifo_empty, pop, push, fire, issuing;

  // Fired instructions not addressed to us, or without exactly one command bit, are dropped.
  assign push_op.cmd.write = bus.instruction[WrBit];
  assign push_op.cmd.read  = bus.instruction[RdBit];
  assign push_op.tag       = bus.instruction[TagLsb +: TAG_W];
  assign push_op.data      = bus.instruction[DATA_W-1:0];
  assign fire = bus.instr_valid && bus.instr_ready;
  assign push = fire && (bus.instruction[IdLsb +: ID_W] == ID_W'(CPU_ID))
                     && (push_op.cmd.write ^ push_op.cmd.read);

  snoop_fifo #(.DEPTH(DEPTH), .WIDTH($bits(op_t))) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (push_op),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef CPU_REQ_PORT_TIMEOUT_EN
  localparam int TimerW = $clog2(TIMEOUT + 1);
  logic [TimerW-1:0] timer_q, timer_d;
`else
  localparam int UnusedTimeout = TIMEOUT;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pop        = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;
`ifdef CPU_REQ_PORT_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          op_d    = fifo_head;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.bus_gnt) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = op_q.cmd.read ? ST_WAIT : ST_IDLE;
`ifdef CPU_REQ_PORT_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      ST_WAIT: begin
        // A match on the last allowed cycle takes priority over the timeout.
        if (bus.result_valid && (bus.result_tag == op_q.tag)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus.result_data;
          state_d    = ST_IDLE;
        end
`ifdef CPU_REQ_PORT_TIMEOUT_EN
        else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef CPU_REQ_PORT_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
`ifdef CPU_REQ_PORT_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign issuing         = (state_q == ST_ISSUE);
  assign bus.instr_ready = !fifo_full;
  assign bus.bus_req     = (state_q == ST_REQ) || issuing;
  assign bus.writeOut    = issuing && op_q.cmd.write;
  assign bus.readOut     = issuing && op_q.cmd.read;
  assign bus.tagOut      = issuing ? op_q.tag : '0;
  assign bus.dataOut     = (issuing && op_q.cmd.write) ? op_q.data : '0;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.err         = err_q;

endmodule
